rv32_fetch_stage: RTL and testbench

// - Instruction fetch stage of the RV32IF core. Owns the PC, drives the combinational

---
 rtl/rv32_fetch_stage_if.sv | 22 ++
 rtl/rv32_fetch_stage.sv | 103 ++++++++++
 tb/tb_rv32_fetch_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_stage_if.sv
// Decode-side handshake of the RV32IF fetch stage: buffer head {pc, instr} with valid/ready.
// The master modport is the fetch stage; the slave modport is decode.
interface rv32_fetch_stage_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    modport master (
        output id_valid,
        output id_instr,
        output id_pc,
        input  id_ready
    );

    modport slave (
        input  id_valid,
        input  id_instr,
        input  id_pc,
        output id_ready
    );
endinterface

// File: rtl/rv32_fetch_stage.sv
// RV32IF fetch stage: owns the PC, reads instruction memory and queues {pc, instr} in a 2-entry buffer.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned redirect raises a sticky misalign_fault instead of being aligned.
module rv32_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 100
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        imem_pc,
    input  logic [31:0]        imem_instr,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    rv32_fetch_stage_if.master id_bus,
    output logic               fetch_end,
    output logic               misalign_fault
);
    // Widened to 33 bits so a PC near 2^32 cannot wrap back into range.
    localparam logic [32:0] LAST_FETCH = 33'(IMEM_BYTES) - 33'd4;

    logic [31:0] pc_q;
    logic [1:0]  count_q;
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_instr_q [2];

    logic        in_range;
    logic        head_valid;
    logic        pop;
    logic        push;
    logic        fault_q;
    logic [31:0] redirect_target;

    assign in_range   = ({1'b0, pc_q} <= LAST_FETCH);
    assign head_valid = !reset && (count_q != 2'd0);
    assign pop        = head_valid && id_bus.id_ready;

`ifdef FETCH_MISALIGN_CHK_EN
    logic redirect_bad;

    assign redirect_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_bad ? pc_q : redirect_pc;

    // Sticky until reset; blocks further fetching once set.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (redirect_bad) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign fault_q         = 1'b0;
`endif

    assign push = !reset && !redirect_valid && in_range && !fault_q &&
                  ((count_q != 2'd2) || pop);

    // PC, pointers and occupancy; redirect flushes and discards any same-cycle pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_target;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                pc_q     <= pc_q + 32'd4;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: it is only observed when count_q says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]    <= pc_q;
            buf_instr_q[wr_ptr_q] <= imem_instr;
        end
    end

    assign imem_pc         = pc_q;
    assign fetch_end       = !reset && !in_range;
    assign misalign_fault  = fault_q;

    assign id_bus.id_valid = head_valid;
    assign id_bus.id_pc    = head_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
    assign id_bus.id_instr = head_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Scoreboard bench for rv32_fetch_stage: directed fetch/stall/redirect/reset scenarios against a 100-byte memory image.
// Expected deliveries are queued by the stimulus and consumed by a negedge monitor on each accepted handshake.
module tb_rv32_fetch_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_end;
    logic        misalign_fault;

    logic [31:0] mem [32];
    exp_t        exp_q [$];
    int          checks;
    int          errors;

    rv32_fetch_stage_if dec_if ();

    rv32_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_pc       (imem_pc),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_bus        (dec_if),
        .fetch_end     (fetch_end),
        .misalign_fault(misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = (imem_pc <= 32'd96) ? mem[imem_pc[6:2]] : 32'h0;

    task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_if.id_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectFetch(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back('{pc: pc, instr: instr});
    endtask

    // Inputs settle 1ns after posedge, so a negedge handshake is exactly the pop at the next edge.
    always @(negedge clk) begin
        if (!reset && !redirect_valid && dec_if.id_valid && dec_if.id_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_delivery: got pc=0x%08h instr=0x%08h expected none",
                         dec_if.id_pc, dec_if.id_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (dec_if.id_pc !== e.pc || dec_if.id_instr !== e.instr) begin
                    errors++;
                    $display("[TB] FAIL delivery: got pc=0x%08h instr=0x%08h expected pc=0x%08h instr=0x%08h",
                             dec_if.id_pc, dec_if.id_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + i;
        mem[0]  = 32'h4040_02B7;
        mem[1]  = 32'h4000_0337;
        mem[2]  = 32'hF002_8053;
        mem[9]  = 32'h0010_7153;
        mem[24] = 32'h0000_0013;

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick(3);
        $display("[TB] reset state");
        checkOutput("rst_id_valid", 32'(dec_if.id_valid), 32'd0);
        checkOutput("rst_id_pc", dec_if.id_pc, 32'h0);
        checkOutput("rst_id_instr", dec_if.id_instr, 32'h0);
        checkOutput("rst_fetch_end", 32'(fetch_end), 32'd0);
        checkOutput("rst_misalign", 32'(misalign_fault), 32'd0);
        checkOutput("rst_imem_pc", imem_pc, 32'h0);

        $display("[TB] T1 streaming from reset");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        expectFetch(32'h0, 32'h4040_02B7);
        expectFetch(32'h4, 32'h4000_0337);
        expectFetch(32'h8, 32'hF002_8053);
        checkOutput("t1_c0_id_valid", 32'(dec_if.id_valid), 32'd0);
        tick(1);
        checkOutput("t1_c1_id_pc", dec_if.id_pc, 32'h0);
        tick(2);
        checkOutput("t1_c3_id_instr", dec_if.id_instr, 32'hF002_8053);
        tick(1);

        $display("[TB] T2 backpressure");
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t2_flush_id_valid", 32'(dec_if.id_valid), 32'd0);
        tick(3);
        checkOutput("t2_full_imem_pc", imem_pc, 32'h8);
        checkOutput("t2_full_id_pc", dec_if.id_pc, 32'h0);
        checkOutput("t2_full_id_valid", 32'(dec_if.id_valid), 32'd1);
        expectFetch(32'h0, 32'h4040_02B7);
        expectFetch(32'h4, 32'h4000_0337);
        expectFetch(32'h8, 32'hF002_8053);
        expectFetch(32'hC, 32'hA500_0003);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick(4);

        $display("[TB] T3 redirect while full");
        checkOutput("t3_pre_id_pc", dec_if.id_pc, 32'h10);
        checkOutput("t3_pre_imem_pc", imem_pc, 32'h18);
        applyStimulus(1'b0, 1'b1, 32'h24, 1'b0);
        expectFetch(32'h24, 32'h0010_7153);
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_n1_id_valid", 32'(dec_if.id_valid), 32'd0);
        checkOutput("t3_n1_imem_pc", imem_pc, 32'h24);
        tick(1);
        checkOutput("t3_n2_id_pc", dec_if.id_pc, 32'h24);
        checkOutput("t3_n2_id_instr", dec_if.id_instr, 32'h0010_7153);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1);

        $display("[TB] T4 end of memory");
        applyStimulus(1'b0, 1'b1, 32'h60, 1'b0);
        expectFetch(32'h60, 32'h0000_0013);
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t4_n1_id_valid", 32'(dec_if.id_valid), 32'd0);
        checkOutput("t4_n1_fetch_end", 32'(fetch_end), 32'd0);
        tick(1);
        checkOutput("t4_n2_fetch_end", 32'(fetch_end), 32'd1);
        checkOutput("t4_n2_id_pc", dec_if.id_pc, 32'h60);
        tick(1);
        checkOutput("t4_drain_id_valid", 32'(dec_if.id_valid), 32'd0);
        checkOutput("t4_drain_imem_pc", imem_pc, 32'h64);
        tick(2);
        checkOutput("t4_hold_imem_pc", imem_pc, 32'h64);
        checkOutput("t4_hold_fetch_end", 32'(fetch_end), 32'd1);

        $display("[TB] T5 misaligned redirect");
        applyStimulus(1'b0, 1'b1, 32'h26, 1'b1);
`ifndef FETCH_MISALIGN_CHK_EN
        expectFetch(32'h24, 32'h0010_7153);
`endif
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t5_n1_id_valid", 32'(dec_if.id_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        checkOutput("t5_n1_misalign", 32'(misalign_fault), 32'd1);
        checkOutput("t5_n1_imem_pc", imem_pc, 32'h64);
        tick(1);
        checkOutput("t5_n2_id_valid", 32'(dec_if.id_valid), 32'd0);
        checkOutput("t5_n2_misalign", 32'(misalign_fault), 32'd1);
`else
        checkOutput("t5_n1_misalign", 32'(misalign_fault), 32'd0);
        checkOutput("t5_n1_imem_pc", imem_pc, 32'h24);
        tick(1);
        checkOutput("t5_n2_id_pc", dec_if.id_pc, 32'h24);
        checkOutput("t5_n2_misalign", 32'(misalign_fault), 32'd0);
`endif
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1);

        $display("[TB] T6 reset mid-stream");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t6_id_valid", 32'(dec_if.id_valid), 32'd0);
        checkOutput("t6_imem_pc", imem_pc, 32'h0);
        checkOutput("t6_misalign", 32'(misalign_fault), 32'd0);
        checkOutput("t6_fetch_end", 32'(fetch_end), 32'd0);
        expectFetch(32'h0, 32'h4040_02B7);
        expectFetch(32'h4, 32'h4000_0337);
        expectFetch(32'h8, 32'hF002_8053);
        tick(4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick(2);

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
